fm_synth: RTL and testbench



---
 rtl/fm_synth.sv | 173 +++++++++++++++++
 tb/tb_fm_synth.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_synth.sv
// Polyphonic FM tone generator: per-voice modulator/carrier NCO pair sharing one
// dual-read sine ROM, voices processed sequentially and mixed into one sample per handshake.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | one cycle after reset, launches the first sample
// S_COMPUTE | voices stepped one per cycle, N_VOICES+3 cycles total
// S_VALID   | sample held stable until the consumer takes it
module fm_synth #(
   parameter int N_VOICES = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_VOICES*24-1:0]  carrier_fcws,
   input  logic [23:0]             mod_fcw,
   input  logic [4:0]              mod_shift,
   input  logic [N_VOICES-1:0]     note_en,
   output logic [13:0]             sample,
   output logic                    sample_valid,
   input  logic                    sample_ready
);

   localparam int VW = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
   localparam int SH = $clog2(N_VOICES);
   localparam int CW = $clog2(N_VOICES + 3);
   localparam int AW = 15 + SH;
   localparam logic [CW-1:0] LAST = CW'(N_VOICES + 2);
   localparam logic [CW-1:0] NV   = CW'(N_VOICES);

   typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_VALID} state_t;

   state_t state, state_nxt;
   logic   start;

   logic [CW-1:0]        cnt;
   logic [23:0]          m_ph [N_VOICES];
   logic [23:0]          c_ph [N_VOICES];
   logic [23:0]          cf_q [N_VOICES];
   logic [23:0]          mf_q;
   logic [4:0]           sh_q;
   logic [N_VOICES-1:0]  en_q;

   logic                 issue;
   logic [VW-1:0]        iv;
   logic [23:0]          m_cur, m_nxt;
   logic                 en_iss;
   logic                 p1_vld;
   logic [VW-1:0]        p1_v;
   logic [23:0]          c_cur, cf_cur, c_nxt;
   logic                 en_p1;
   logic                 p2_vld;
   logic                 p2_en;
   logic signed [13:0]   ms_q;
   logic signed [13:0]   out_q;
   logic [23:0]          ms_ext;
   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] mix;
   logic [13:0]          sat;

   // Full-wave sine table, folded to constants at elaboration.
   logic signed [13:0] sine_rom [2048];
   for (genvar i = 0; i < 2048; i++) begin : g_rom
      assign sine_rom[i] = 14'($rtoi(8191.0 * $sin(6.283185307179586 * i / 2048.0)));
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         S_IDLE: begin
            state_nxt = S_COMPUTE;
            start     = 1'b1;
         end
         S_COMPUTE: begin
            if (cnt == LAST) state_nxt = S_VALID;
         end
         S_VALID: begin
            if (sample_ready) begin
               state_nxt = S_COMPUTE;
               start     = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign sample_valid = (state == S_VALID);
   assign issue        = (state == S_COMPUTE) && (cnt < NV);
   assign iv           = cnt[VW-1:0];

   always_comb begin
      m_cur  = '0;
      en_iss = 1'b0;
      c_cur  = '0;
      cf_cur = '0;
      en_p1  = 1'b0;
      for (int v = 0; v < N_VOICES; v++) begin
         if (iv == VW'(v)) begin
            m_cur  = m_ph[v];
            en_iss = en_q[v];
         end
         if (p1_v == VW'(v)) begin
            c_cur  = c_ph[v];
            cf_cur = cf_q[v];
            en_p1  = en_q[v];
         end
      end
   end

   // Disabled voices load zero so a later enable restarts from phase 0.
   assign ms_ext = {{10{ms_q[13]}}, ms_q};
   assign m_nxt  = en_iss ? (m_cur + mf_q) : '0;
   assign c_nxt  = en_p1 ? (c_cur + cf_cur + (ms_ext << sh_q)) : '0;

   always_ff @(posedge clk) begin
      ms_q  <= sine_rom[m_nxt[23:13]];
      out_q <= sine_rom[c_nxt[23:13]];
   end

   always_comb begin
      mix = acc >>> SH;
      if (int'(mix) > 8191)       sat = 14'h1FFF;
      else if (int'(mix) < -8192) sat = 14'h2000;
      else                        sat = mix[13:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         acc    <= '0;
         sample <= '0;
         p1_vld <= 1'b0;
         p1_v   <= '0;
         p2_vld <= 1'b0;
         p2_en  <= 1'b0;
         mf_q   <= '0;
         sh_q   <= '0;
         en_q   <= '0;
         for (int v = 0; v < N_VOICES; v++) begin
            m_ph[v] <= '0;
            c_ph[v] <= '0;
            cf_q[v] <= '0;
         end
      end else if (start) begin
         cnt    <= '0;
         acc    <= '0;
         p1_vld <= 1'b0;
         p2_vld <= 1'b0;
         mf_q   <= mod_fcw;
         sh_q   <= mod_shift;
         en_q   <= note_en;
         for (int v = 0; v < N_VOICES; v++) cf_q[v] <= carrier_fcws[v*24 +: 24];
      end else if (state == S_COMPUTE) begin
         cnt    <= cnt + CW'(1);
         p1_vld <= issue;
         p1_v   <= iv;
         p2_vld <= p1_vld;
         p2_en  <= en_p1;
         for (int v = 0; v < N_VOICES; v++) begin
            if (issue && (iv == VW'(v)))    m_ph[v] <= m_nxt;
            if (p1_vld && (p1_v == VW'(v))) c_ph[v] <= c_nxt;
         end
         if (p2_vld && p2_en) acc <= acc + AW'(out_q);
         if (cnt == LAST) sample <= sat;
      end
   end

endmodule

// File: tb/tb_fm_synth.sv
// Directed bench for fm_synth: a 1-voice and a 2-voice instance driven through
// reset, FM reference tone, backpressure, pure carrier wrap, voice enable and mix limits.
module tb_fm_synth;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] cf1, mf1, mf2;
   logic [47:0] cf2;
   logic [4:0]  sh1, sh2;
   logic [0:0]  en1;
   logic [1:0]  en2;
   logic        rdy1 = 1'b0, rdy2 = 1'b0;
   logic [13:0] smp1, smp2;
   logic        vld1, vld2;

   int checks   = 0;
   int failures = 0;
   int exp_next [2];
   logic [23:0] mdl_m [2][2];
   logic [23:0] mdl_c [2][2];

   always #4 clk = ~clk;

   fm_synth #(.N_VOICES(1)) u_dut1 (
      .clk(clk), .rst(rst), .carrier_fcws(cf1), .mod_fcw(mf1), .mod_shift(sh1),
      .note_en(en1), .sample(smp1), .sample_valid(vld1), .sample_ready(rdy1));

   fm_synth #(.N_VOICES(2)) u_dut2 (
      .clk(clk), .rst(rst), .carrier_fcws(cf2), .mod_fcw(mf2), .mod_shift(sh2),
      .note_en(en2), .sample(smp2), .sample_valid(vld2), .sample_ready(rdy2));

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int lut(input int i);
      real x;
      x = 8191.0 * $sin(6.283185307179586 * i / 2048.0);
      return $rtoi(x);
   endfunction

   function automatic int cur_sample(input int which);
      return (which != 0) ? int'($signed(smp2)) : int'($signed(smp1));
   endfunction

   function automatic int cur_valid(input int which);
      return (which != 0) ? int'(vld2) : int'(vld1);
   endfunction

   // Reference: one sample step of every voice from the current bench inputs.
   task automatic model_step(input int which, output int res);
      int n, sum, ms, shv;
      logic [23:0] cfv, mfv;
      logic env;
      n   = (which != 0) ? 2 : 1;
      sum = 0;
      for (int v = 0; v < n; v++) begin
         if (which != 0) begin
            cfv = cf2[v*24 +: 24]; mfv = mf2; shv = int'(sh2); env = en2[v];
         end else begin
            cfv = cf1; mfv = mf1; shv = int'(sh1); env = en1[0];
         end
         if (!env) begin
            mdl_m[which][v] = '0;
            mdl_c[which][v] = '0;
         end else begin
            mdl_m[which][v] = mdl_m[which][v] + mfv;
            ms = lut(int'(mdl_m[which][v][23:13]));
            mdl_c[which][v] = mdl_c[which][v] + cfv + 24'(longint'(ms) <<< shv);
            sum += lut(int'(mdl_c[which][v][23:13]));
         end
      end
      if (which != 0) sum = sum >>> 1;
      if (sum > 8191)  sum = 8191;
      if (sum < -8192) sum = -8192;
      res = sum;
   endtask

   task automatic release_reset();
      rst = 1'b0;
      for (int w = 0; w < 2; w++)
         for (int v = 0; v < 2; v++) begin
            mdl_m[w][v] = '0;
            mdl_c[w][v] = '0;
         end
      model_step(0, exp_next[0]);
      model_step(1, exp_next[1]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_valid_v1", int'(vld1), 0);
      check("rst_sample_v1", cur_sample(0), 0);
      check("rst_valid_v2", int'(vld2), 0);
      check("rst_sample_v2", cur_sample(1), 0);
      release_reset();
   endtask

   task automatic wait_valid(input int which, input string tag);
      int cyc;
      cyc = 0;
      while (cur_valid(which) == 0 && cyc < 64) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_valid"}, cur_valid(which), 1);
   endtask

   // Takes one sample with a single-cycle ready pulse; returns at a negedge.
   task automatic pull(input int which, input string tag, output int got);
      wait_valid(which, tag);
      got = cur_sample(which);
      check(tag, got, exp_next[which]);
      if (which != 0) rdy2 = 1'b1;
      else            rdy1 = 1'b1;
      model_step(which, exp_next[which]);
      @(negedge clk);
      rdy1 = 1'b0;
      rdy2 = 1'b0;
   endtask

   initial begin
      int got, cyc;
      cf1 = 24'd123033; mf1 = 24'd223696; sh1 = 5'd8; en1 = 1'b1;
      cf2 = '0; mf2 = '0; sh2 = '0; en2 = 2'b11;

      // Reset values and first-sample latency
      do_reset();
      cyc = 0;
      while (!vld1 && cyc < 64) begin
         @(negedge clk);
         cyc++;
      end
      check("first_valid_latency", cyc, 5);

      // FM reference tone, one voice
      for (int k = 1; k <= 10; k++) pull(0, $sformatf("fm_s%0d", k), got);

      // Backpressure: sample must hold and the sequence continue unaffected
      wait_valid(0, "stall");
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (i == 50 || i == 99) begin
            check("stall_valid", int'(vld1), 1);
            check("stall_sample", cur_sample(0), exp_next[0]);
         end
      end
      pull(0, "post_stall_a", got);
      // ready raised while computing must not cause a transfer
      rdy1 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rdy1 = 1'b0;
      pull(0, "post_stall_b", got);
      pull(0, "post_stall_c", got);

      // Pure carrier: sample n = LUT[n mod 2048]
      cf1 = 24'd8192; mf1 = '0; sh1 = '0; en1 = 1'b1;
      do_reset();
      for (int n = 1; n <= 2050; n++) begin
         pull(0, "carrier", got);
         if (n == 1)    check("carrier_s1", got, 25);
         if (n == 2)    check("carrier_s2", got, 50);
         if (n == 3)    check("carrier_s3", got, 75);
         if (n == 2048) check("carrier_wrap0", got, 0);
         if (n == 2049) check("carrier_wrap1", got, 25);
      end

      // Reset mid-COMPUTE and while VALID restart the sequence
      cf1 = 24'd123033; mf1 = 24'd223696; sh1 = 5'd8;
      do_reset();
      pull(0, "pre_rst_s1", got);
      pull(0, "pre_rst_s2", got);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_valid", int'(vld1), 0);
      check("midrst_sample", cur_sample(0), 0);
      release_reset();
      pull(0, "restart_s1", got);
      pull(0, "restart_s2", got);
      wait_valid(0, "validrst");
      rst = 1'b1;
      @(negedge clk);
      check("validrst_valid", int'(vld1), 0);
      release_reset();
      pull(0, "restart2_s1", got);

      // Voice disable / restart on the 2-voice instance
      cf2 = {24'd16384, 24'd8192}; mf2 = '0; sh2 = '0; en2 = 2'b01;
      do_reset();
      pull(1, "en01_s1", got);
      check("en01_s1_hand", got, 12);
      pull(1, "en01_s2", got);
      pull(1, "en01_s3", got);
      en2 = 2'b11;
      pull(1, "en01_s4", got);
      pull(1, "en11_s5", got);
      check("en11_s5_hand", got, 87);
      en2 = 2'b10;
      pull(1, "en11_s6", got);
      pull(1, "en10_s7", got);
      en2 = 2'b11;
      pull(1, "en10_s8", got);
      pull(1, "en11_s9", got);
      pull(1, "en11_s10", got);

      // Two-voice FM, independent carriers
      cf2 = {24'd223696, 24'd123033}; mf2 = 24'd223696; sh2 = 5'd8; en2 = 2'b11;
      do_reset();
      for (int k = 1; k <= 6; k++) pull(1, $sformatf("fm2_s%0d", k), got);

      // Full-amplitude voices in phase stay within the output range
      cf2 = {24'd4194304, 24'd4194304}; mf2 = '0; sh2 = '0; en2 = 2'b11;
      do_reset();
      pull(1, "sat_s1", got);
      check("sat_s1_hand", got, 8191);
      pull(1, "sat_s2", got);
      check("sat_s2_hand", got, 0);
      pull(1, "sat_s3", got);
      check("sat_s3_hand", got, -8191);
      check("sat_range", int'(got >= -8192 && got <= 8191), 1);
      pull(1, "sat_s4", got);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
